// File: rtl/bvh_fetch_arbiter_if.sv
// Requester/memory bus of the BVH fetch arbiter: request/grant/response lanes plus the shared read port.
interface bvh_fetch_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 256
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic                      mem_rd_en;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_rd_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;

   modport slave (
      input  req, req_lock, req_addr, mem_rd_data,
      output gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data
   );

   modport master (
      output req, req_lock, req_addr, mem_rd_data,
      input  gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bvh_fetch_arbiter.sv
// Round-robin arbiter sharing one BVH memory read port, with bounded burst locking and a
// one-hot tag pipeline that routes each read's data back to the requester that issued it.
module bvh_fetch_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 256,
   parameter int MEM_LATENCY = 2,
   parameter int BURST_MAX   = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   bvh_fetch_arbiter_if.slave   bus,
   output logic                 busy
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [DATA_W-1:0] DATA_ZERO = '0;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} state_t;

   state_t                           state_reg;
   logic [IDX_W-1:0]                 rr_reg;
   logic [IDX_W-1:0]                 owner_reg;
   logic [CNT_W-1:0]                 burst_cnt_reg;
   logic [MEM_LATENCY:0][NUM_REQ-1:0] tag_reg;

   logic [NUM_REQ-1:0] gnt_comb;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               found;
   logic               burst_done;
   int                 cand;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (i == IDX_W'(NUM_REQ - 1))
         return '0;
      return i + 1'b1;
   endfunction

   // Locked: only the owner may win; idle: first active requester from rr upward.
   always_comb begin
      gnt_comb = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = 0;
      if (resetn) begin
         if (state_reg == ARB_LOCKED) begin
            gnt_comb[owner_reg] = bus.req[owner_reg];
            gnt_idx             = owner_reg;
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               cand = (int'(rr_reg) + k) % NUM_REQ;
               if (!found && bus.req[cand]) begin
                  found   = 1'b1;
                  gnt_idx = IDX_W'(cand);
               end
            end
            if (found)
               gnt_comb[gnt_idx] = 1'b1;
         end
      end
   end

   assign gnt_any    = |gnt_comb;
   assign burst_done = gnt_any && (burst_cnt_reg == CNT_W'(BURST_MAX - 1));
   assign bus.gnt    = gnt_comb;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ARB_IDLE;
         rr_reg        <= '0;
         owner_reg     <= '0;
         burst_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (gnt_any) begin
                  rr_reg <= next_idx(gnt_idx);
                  if (BURST_MAX > 1 && bus.req_lock[gnt_idx]) begin
                     owner_reg     <= gnt_idx;
                     burst_cnt_reg <= CNT_W'(1);
                     state_reg     <= ARB_LOCKED;
                  end
               end
            end
            ARB_LOCKED: begin
               if (gnt_any)
                  burst_cnt_reg <= burst_cnt_reg + 1'b1;
               // A grant in the releasing cycle still issues; rr then favours the next requester.
               if (!bus.req_lock[owner_reg] || burst_done) begin
                  state_reg     <= ARB_IDLE;
                  rr_reg        <= next_idx(owner_reg);
                  burst_cnt_reg <= '0;
               end
            end
            default: state_reg <= ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.mem_rd_en <= 1'b0;
         bus.mem_addr  <= '0;
      end else begin
         bus.mem_rd_en <= gnt_any;
         if (gnt_any)
            bus.mem_addr <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
      end
   end

   // Stage 0 lines up with mem_rd_en, the last stage with the returning mem_rd_data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         tag_reg <= '0;
      else
         tag_reg <= {tag_reg[MEM_LATENCY-1:0], gnt_comb};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.rsp_valid <= '0;
         bus.rsp_data  <= DATA_ZERO;
      end else begin
         bus.rsp_valid <= tag_reg[MEM_LATENCY];
         if (|tag_reg[MEM_LATENCY])
            bus.rsp_data <= bus.mem_rd_data;
      end
   end

   assign busy = (state_reg == ARB_LOCKED) | (|tag_reg) | bus.mem_rd_en;

endmodule

// File: tb/tb_bvh_fetch_arbiter.sv
// Directed bench for bvh_fetch_arbiter: a 2-requester instance for T1-T5, a 4-requester one for T6.
module tb_bvh_fetch_arbiter;
   localparam int ML = 2;
   localparam int AW = 16;
   localparam int DW = 256;

   logic clk;
   logic resetn;
   logic busy0;
   logic busy1;
   int   checks = 0;
   int   errors = 0;

   bvh_fetch_arbiter_if #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) m0 ();
   bvh_fetch_arbiter_if #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW)) m1 ();

   bvh_fetch_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML), .BURST_MAX(8)) dut0 (
      .clk(clk), .resetn(resetn), .bus(m0), .busy(busy0)
   );
   bvh_fetch_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(ML), .BURST_MAX(8)) dut1 (
      .clk(clk), .resetn(resetn), .bus(m1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return {8{(a ^ 16'hC0DE), a}};
   endfunction

   // Fixed-latency memory: address seen with mem_rd_en returns ML cycles later.
   logic [AW-1:0] pa0 [ML];
   logic [AW-1:0] pa1 [ML];
   always @(posedge clk) begin
      pa0[0] <= m0.mem_addr;
      pa1[0] <= m1.mem_addr;
      for (int i = 1; i < ML; i++) begin
         pa0[i] <= pa0[i-1];
         pa1[i] <= pa1[i-1];
      end
   end
   assign m0.mem_rd_data = mdata(pa0[ML-1]);
   assign m1.mem_rd_data = mdata(pa1[ML-1]);

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      m0.req      = '0;
      m0.req_lock = '0;
      m0.req_addr = '0;
      m1.req      = '0;
      m1.req_lock = '0;
      m1.req_addr = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      resetn      = 1'b1;
      m0.req      = 2'b01;
      m0.req_lock = '0;
      m0.req_addr = '0;
      m1.req      = '0;
      m1.req_lock = '0;
      m1.req_addr = '0;
      #2 resetn = 1'b0;
      #1;
      chk("rst_gnt", m0.gnt, 2'b00);
      chk("rst_rd_en", m0.mem_rd_en, 1'b0);
      chk("rst_addr", m0.mem_addr, 16'h0);
      chk("rst_rsp_valid", m0.rsp_valid, 2'b00);
      chk("rst_rsp_data", m0.rsp_data, '0);
      chk("rst_busy", busy0, 1'b0);
      $display("reset: checks=%0d", checks);

      // T1: single read, latency MEM_LATENCY+2
      do_reset();
      m0.req = 2'b01; m0.req_addr = {16'h0000, 16'h0010}; #1;
      chk("t1_gnt_c0", m0.gnt, 2'b01);
      tick(); m0.req = 2'b00; #1;
      chk("t1_gnt_c1", m0.gnt, 2'b00);
      chk("t1_rd_en_c1", m0.mem_rd_en, 1'b1);
      chk("t1_addr_c1", m0.mem_addr, 16'h0010);
      chk("t1_busy_c1", busy0, 1'b1);
      tick();
      chk("t1_rd_en_c2", m0.mem_rd_en, 1'b0);
      chk("t1_addr_hold_c2", m0.mem_addr, 16'h0010);
      tick();
      chk("t1_rsp_c3", m0.rsp_valid, 2'b00);
      tick();
      chk("t1_rsp_c4", m0.rsp_valid, 2'b01);
      chk("t1_data_c4", m0.rsp_data, mdata(16'h0010));
      tick();
      chk("t1_rsp_c5", m0.rsp_valid, 2'b00);
      chk("t1_data_hold_c5", m0.rsp_data, mdata(16'h0010));
      chk("t1_busy_c5", busy0, 1'b0);
      $display("T1 single read: checks=%0d errors=%0d", checks, errors);

      // T2: alternating round-robin, responses in issue order
      do_reset();
      m0.req_addr = {16'h0200, 16'h0100};
      for (int c = 0; c <= 8; c++) begin
         m0.req = (c < 4) ? 2'b11 : 2'b00; #1;
         chk($sformatf("t2_gnt_c%0d", c), m0.gnt, (c < 4) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00);
         if (c >= 1 && c <= 4)
            chk($sformatf("t2_addr_c%0d", c), m0.mem_addr, ((c - 1) % 2) ? 16'h0200 : 16'h0100);
         if (c >= 4 && c <= 7) begin
            chk($sformatf("t2_rsp_c%0d", c), m0.rsp_valid, ((c - 4) % 2) ? 2'b10 : 2'b01);
            chk($sformatf("t2_data_c%0d", c), m0.rsp_data,
                mdata(((c - 4) % 2) ? 16'h0200 : 16'h0100));
         end
         if (c == 8)
            chk("t2_rsp_c8", m0.rsp_valid, 2'b00);
         tick();
      end
      $display("T2 round robin: checks=%0d errors=%0d", checks, errors);

      // T3: lock released in cycle 3, that grant is the final beat
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         m0.req = 2'b11; m0.req_lock = (c < 3) ? 2'b01 : 2'b00; #1;
         chk($sformatf("t3_gnt_c%0d", c), m0.gnt, (c < 4) ? 2'b01 : 2'b10);
         if (c == 1)
            chk("t3_busy_c1", busy0, 1'b1);
         tick();
      end
      $display("T3 lock release: checks=%0d errors=%0d", checks, errors);

      // T4: burst cap of 8 forces a hand-off, then lock is re-entered
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         m0.req = 2'b11; m0.req_lock = 2'b01; #1;
         chk($sformatf("t4_gnt_c%0d", c), m0.gnt, (c == 8) ? 2'b10 : 2'b01);
         tick();
      end
      $display("T4 burst cap: checks=%0d errors=%0d", checks, errors);

      // T5: reset with two reads in flight discards them
      do_reset();
      m0.req = 2'b01; m0.req_addr = {16'h0040, 16'h0030}; #1;
      chk("t5_gnt_c0", m0.gnt, 2'b01);
      tick(); m0.req = 2'b10; #1;
      chk("t5_gnt_c1", m0.gnt, 2'b10);
      tick(); m0.req = 2'b11; resetn = 1'b0; #1;
      chk("t5_gnt_rst", m0.gnt, 2'b00);
      chk("t5_rd_en_rst", m0.mem_rd_en, 1'b0);
      chk("t5_addr_rst", m0.mem_addr, 16'h0);
      chk("t5_rsp_rst", m0.rsp_valid, 2'b00);
      chk("t5_data_rst", m0.rsp_data, '0);
      chk("t5_busy_rst", busy0, 1'b0);
      tick(); resetn = 1'b1; m0.req = 2'b00; #1;
      for (int c = 3; c <= 6; c++) begin
         chk($sformatf("t5_rsp_c%0d", c), m0.rsp_valid, 2'b00);
         chk($sformatf("t5_busy_c%0d", c), busy0, 1'b0);
         tick();
      end
      $display("T5 reset in flight: checks=%0d errors=%0d", checks, errors);

      // T6: four requesters, wrap-around skips idle requester 2
      do_reset();
      m1.req_addr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      m1.req = 4'b0100; #1;
      chk("t6_gnt_c0", m1.gnt, 4'b0100);
      tick(); m1.req = 4'b1011; #1;
      chk("t6_gnt_c1", m1.gnt, 4'b1000);
      tick();
      chk("t6_gnt_c2", m1.gnt, 4'b0001);
      chk("t6_addr_c2", m1.mem_addr, 16'h3333);
      tick();
      chk("t6_gnt_c3", m1.gnt, 4'b0010);
      chk("t6_addr_c3", m1.mem_addr, 16'h0000);
      tick();
      chk("t6_gnt_c4", m1.gnt, 4'b1000);
      chk("t6_addr_c4", m1.mem_addr, 16'h1111);
      m1.req = 4'b0000;
      tick();
      $display("T6 four requesters: checks=%0d errors=%0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
